// File: rtl/uart_tx_serializer.sv
// UART transmit serializer: start bit, LSB-first data, optional parity, stop bits.
// Bit timing comes only from the external baud_tick strobe. All outputs are registered.
module uart_tx_serializer #(
    parameter int unsigned DATA_BITS = 8,
    parameter int unsigned STOP_BITS = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 baud_tick,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 parity_en,
    input  logic                 parity_odd,
    output logic                 tx,
    output logic                 tx_busy,
    output logic                 tx_done
);

    localparam int unsigned     CNT_W     = $clog2(DATA_BITS + 1);
    localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(DATA_BITS - 1);
    localparam logic [1:0]       LAST_STOP = 2'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARM,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t                 r_state;
    logic [DATA_BITS-1:0]   r_shift;
    logic [CNT_W-1:0]       r_bit_cnt;
    logic [1:0]             r_stop_cnt;
    logic                   r_par_en;
    logic                   r_par_bit;
    logic                   r_tx;
    logic                   r_ready;
    logic                   r_busy;
    logic                   r_done;

    state_t                 w_state_nxt;
    logic [DATA_BITS-1:0]   w_shift_nxt;
    logic [CNT_W-1:0]       w_bit_cnt_nxt;
    logic [1:0]             w_stop_cnt_nxt;
    logic                   w_par_en_nxt;
    logic                   w_par_bit_nxt;
    logic                   w_tx_nxt;
    logic                   w_ready_nxt;
    logic                   w_busy_nxt;
    logic                   w_done_nxt;

    assign tx       = r_tx;
    assign tx_ready = r_ready;
    assign tx_busy  = r_busy;
    assign tx_done  = r_done;

    // State, datapath and output registers; outputs are precomputed from next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_shift    <= '0;
            r_bit_cnt  <= '0;
            r_stop_cnt <= '0;
            r_par_en   <= 1'b0;
            r_par_bit  <= 1'b0;
            r_tx       <= 1'b1;
            r_ready    <= 1'b1;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_shift    <= w_shift_nxt;
            r_bit_cnt  <= w_bit_cnt_nxt;
            r_stop_cnt <= w_stop_cnt_nxt;
            r_par_en   <= w_par_en_nxt;
            r_par_bit  <= w_par_bit_nxt;
            r_tx       <= w_tx_nxt;
            r_ready    <= w_ready_nxt;
            r_busy     <= w_busy_nxt;
            r_done     <= w_done_nxt;
        end
    end

    // Next-state sequencing: each baud_tick closes the current bit period.
    always_comb begin
        w_state_nxt    = r_state;
        w_shift_nxt    = r_shift;
        w_bit_cnt_nxt  = r_bit_cnt;
        w_stop_cnt_nxt = r_stop_cnt;
        w_par_en_nxt   = r_par_en;
        w_par_bit_nxt  = r_par_bit;
        w_done_nxt     = 1'b0;
        w_tx_nxt       = 1'b1;

        case (r_state)
            S_IDLE: begin
                if (tx_valid && r_ready) begin
                    w_shift_nxt   = tx_data;
                    w_par_en_nxt  = parity_en;
                    w_par_bit_nxt = (^tx_data) ^ parity_odd;
                    w_state_nxt   = S_ARM;
                end
            end
            S_ARM: begin
                // A tick in the accept cycle was seen in IDLE, so it never reaches here.
                if (baud_tick) begin
                    w_state_nxt = S_START;
                end
            end
            S_START: begin
                if (baud_tick) begin
                    w_state_nxt   = S_DATA;
                    w_bit_cnt_nxt = '0;
                end
            end
            S_DATA: begin
                if (baud_tick) begin
                    w_shift_nxt   = r_shift >> 1;
                    w_bit_cnt_nxt = r_bit_cnt + CNT_W'(1);
                    if (r_bit_cnt == LAST_BIT) begin
                        if (r_par_en) begin
                            w_state_nxt = S_PARITY;
                        end else begin
                            w_state_nxt    = S_STOP;
                            w_stop_cnt_nxt = '0;
                        end
                    end
                end
            end
            S_PARITY: begin
                if (baud_tick) begin
                    w_state_nxt    = S_STOP;
                    w_stop_cnt_nxt = '0;
                end
            end
            S_STOP: begin
                if (baud_tick) begin
                    if (r_stop_cnt == LAST_STOP) begin
                        w_state_nxt = S_IDLE;
                        w_done_nxt  = 1'b1;
                    end else begin
                        w_stop_cnt_nxt = r_stop_cnt + 2'd1;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        case (w_state_nxt)
            S_START:  w_tx_nxt = 1'b0;
            S_DATA:   w_tx_nxt = w_shift_nxt[0];
            S_PARITY: w_tx_nxt = w_par_bit_nxt;
            default:  w_tx_nxt = 1'b1;
        endcase

        w_ready_nxt = (w_state_nxt == S_IDLE);
        w_busy_nxt  = (w_state_nxt != S_IDLE);
    end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Self-checking bench for uart_tx_serializer: 8N1 instance against a bit-queue
// reference model, plus a 7-data/2-stop instance with a directed frame.
module tb_uart_tx_serializer;

    localparam int unsigned DB = 8;
    localparam int unsigned SB = 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Main 8N1 instance
    logic       rst;
    logic       baud_tick;
    logic       tx_valid;
    logic       tx_ready;
    logic [7:0] tx_data;
    logic       parity_en;
    logic       parity_odd;
    logic       tx;
    logic       tx_busy;
    logic       tx_done;

    // 7-data, 2-stop instance
    logic       rst2;
    logic       tick2;
    logic       valid2;
    logic       ready2;
    logic [6:0] data2;
    logic       pen2;
    logic       podd2;
    logic       tx2;
    logic       busy2;
    logic       done2;

    uart_tx_serializer #(.DATA_BITS(DB), .STOP_BITS(SB)) u_dut (
        .clk(clk), .rst(rst), .baud_tick(baud_tick),
        .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_data(tx_data),
        .parity_en(parity_en), .parity_odd(parity_odd),
        .tx(tx), .tx_busy(tx_busy), .tx_done(tx_done)
    );

    uart_tx_serializer #(.DATA_BITS(7), .STOP_BITS(2)) u_dut72 (
        .clk(clk), .rst(rst2), .baud_tick(tick2),
        .tx_valid(valid2), .tx_ready(ready2), .tx_data(data2),
        .parity_en(pen2), .parity_odd(podd2),
        .tx(tx2), .tx_busy(busy2), .tx_done(done2)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model: the frame is a queue of line levels, one per bit period.
    bit   m_idle = 1'b1;
    bit   m_pend = 1'b0;
    bit   m_cur  = 1'b1;
    bit   m_done = 1'b0;
    bit   m_q[$];
    int   exp_len  = 0;
    int   tick_per = 16;
    int   tick_ph  = 0;
    int   cyc_no   = 0;
    int   fall_cyc = -1;

    int   exp2 [10] = '{0, 1, 0, 0, 0, 0, 0, 1, 1, 1};
    logic bits2[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic build_frame(input logic [7:0] d, input logic pen, input logic podd);
        m_q.delete();
        m_q.push_back(1'b0);
        for (int i = 0; i < int'(DB); i++) m_q.push_back(d[i]);
        if (pen) m_q.push_back(1'(($countones(d) % 2) != 0) ^ podd);
        for (int i = 0; i < int'(SB); i++) m_q.push_back(1'b1);
        exp_len = 1 + int'(DB) + int'(pen) + int'(SB);
    endtask

    // One clock: drive tick, advance the model with the inputs seen at the edge, check outputs.
    task automatic cyc();
        logic       s_rst, s_tick, s_valid, s_pen, s_podd;
        logic [7:0] s_data;
        logic       e_tx;
        baud_tick = ((tick_ph % tick_per) == tick_per - 1);
        tick_ph++;
        s_rst = rst; s_tick = baud_tick; s_valid = tx_valid;
        s_data = tx_data; s_pen = parity_en; s_podd = parity_odd;
        @(posedge clk);
        #1;
        cyc_no++;
        m_done = 1'b0;
        if (s_rst) begin
            m_idle = 1'b1; m_pend = 1'b0; m_q.delete();
        end else if (m_idle) begin
            if (s_valid) begin
                build_frame(s_data, s_pen, s_podd);
                m_idle = 1'b0; m_pend = 1'b1;
            end
        end else if (m_pend) begin
            if (s_tick) begin
                m_cur = m_q.pop_front(); m_pend = 1'b0;
            end
        end else if (s_tick) begin
            if (m_q.size() == 0) begin
                m_idle = 1'b1; m_done = 1'b1;
            end else begin
                m_cur = m_q.pop_front();
            end
        end
        e_tx = (m_idle || m_pend) ? 1'b1 : m_cur;
        chk("tx",       32'(tx),       32'(e_tx));
        chk("tx_ready", 32'(tx_ready), 32'(m_idle));
        chk("tx_busy",  32'(tx_busy),  32'(!m_idle));
        chk("tx_done",  32'(tx_done),  32'(m_done));
        if (fall_cyc < 0 && tx_busy === 1'b1 && tx === 1'b0) fall_cyc = cyc_no;
        if (tx_done === 1'b1) begin
            if (fall_cyc >= 0) chk("frame_len", 32'(cyc_no - fall_cyc), 32'(exp_len * tick_per));
            fall_cyc = -1;
        end
        if (s_rst) fall_cyc = -1;
    endtask

    task automatic run_until_done(input int max);
        int n;
        n = 0;
        do begin
            cyc();
            n++;
        end while (tx_done !== 1'b1 && n < max);
        chk("done_seen", 32'(tx_done), 32'd1);
    endtask

    task automatic send(input logic [7:0] d, input logic pen, input logic podd);
        tx_data = d; parity_en = pen; parity_odd = podd; tx_valid = 1'b1;
        cyc();
        tx_valid = 1'b0;
        // Inputs change mid-frame; the frame in flight must not notice.
        tx_data = 8'($urandom); parity_en = 1'($urandom); parity_odd = 1'($urandom);
        run_until_done(2000);
        cyc();
    endtask

    initial begin
        int n;
        int ph;
        int ready_bad;
        bit seen_fall;
        bit done2_seen;

        rst = 1'b1; baud_tick = 1'b0; tx_valid = 1'b0; tx_data = 8'h00;
        parity_en = 1'b0; parity_odd = 1'b0;
        rst2 = 1'b1; tick2 = 1'b0; valid2 = 1'b0; data2 = 7'h00; pen2 = 1'b0; podd2 = 1'b0;

        // Reset state
        cyc(); cyc();
        chk("reset_tx", 32'(tx), 32'd1);
        chk("reset_ready", 32'(tx_ready), 32'd1);
        rst = 1'b0;
        repeat (3) cyc();

        // 8N1 and parity frames, tick every 16 clocks
        tick_per = 16;
        send(8'hA5, 1'b0, 1'b0);
        send(8'hA5, 1'b1, 1'b0);
        send(8'hA5, 1'b1, 1'b1);
        send(8'h07, 1'b1, 1'b0);

        // Back-to-back with tx_valid held high
        tx_data = 8'h55; parity_en = 1'b0; tx_valid = 1'b1;
        cyc();
        tx_data = 8'hAA;
        run_until_done(2000);
        cyc();
        chk("b2b_accept_busy", 32'(tx_busy), 32'd1);
        tx_valid = 1'b0; tx_data = 8'h0F;
        run_until_done(2000);
        cyc();

        // Reset during data bit 3
        tick_per = 8;
        tx_data = 8'hC3; tx_valid = 1'b1;
        cyc();
        tx_valid = 1'b0;
        n = 0;
        while ((m_pend || m_q.size() > 5) && n < 500) begin
            cyc();
            n++;
        end
        repeat (3) cyc();
        rst = 1'b1;
        cyc();
        chk("midrst_tx", 32'(tx), 32'd1);
        chk("midrst_ready", 32'(tx_ready), 32'd1);
        chk("midrst_done", 32'(tx_done), 32'd0);
        rst = 1'b0;
        repeat (20) cyc();
        send(8'h3C, 1'b0, 1'b0);

        // baud_tick held high, including in the accept cycle
        tick_per = 1;
        send(8'h5A, 1'b0, 1'b0);
        send(8'h96, 1'b1, 1'b1);

        // Randomized frames, tick periods and idle gaps
        for (int k = 0; k < 40; k++) begin
            tick_per = int'($urandom_range(1, 6));
            repeat ($urandom_range(0, 5)) cyc();
            send(8'($urandom), 1'($urandom), 1'($urandom));
        end

        // 7 data bits, 2 stop bits: 0x41
        @(posedge clk); #1;
        chk("i72_reset_tx", 32'(tx2), 32'd1);
        chk("i72_reset_ready", 32'(ready2), 32'd1);
        chk("i72_reset_busy", 32'(busy2), 32'd0);
        rst2 = 1'b0;
        valid2 = 1'b1; data2 = 7'h41;
        @(posedge clk); #1;
        valid2 = 1'b0; data2 = 7'h3E;
        chk("i72_busy", 32'(busy2), 32'd1);
        ph = 0; ready_bad = 0; seen_fall = 1'b0; done2_seen = 1'b0; n = 0;
        while (!done2_seen && n < 400) begin
            tick2 = ((ph % 4) == 3);
            ph++;
            if (tx2 === 1'b0) seen_fall = 1'b1;
            if (tick2 && seen_fall) bits2.push_back(tx2);
            @(posedge clk); #1;
            n++;
            if (done2 === 1'b1) done2_seen = 1'b1;
            else if (ready2 !== 1'b0) ready_bad++;
        end
        tick2 = 1'b0;
        chk("i72_done_seen", 32'(done2_seen), 32'd1);
        chk("i72_ready_low", 32'(ready_bad), 32'd0);
        chk("i72_nbits", 32'(bits2.size()), 32'd10);
        for (int i = 0; i < 10; i++)
            chk($sformatf("i72_bit%0d", i),
                (i < bits2.size()) ? 32'(bits2[i]) : 32'hFFFF_FFFF, 32'(exp2[i]));
        chk("i72_end_tx", 32'(tx2), 32'd1);
        chk("i72_end_ready", 32'(ready2), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
